sequenciador_pc: RTL and testbench
==================================

# sequenciador_pc

Multi-cycle fetch/execute sequencer that drives the 8-bit program counter of the processor. It requests instruction fetches, sequences decode and execute, and computes the next PC value: sequential, jump, conditional branch, call or return. It loads that value into the PC through the PC's active-low load control. It sits between the PC register, the instruction memory and the decoder/datapath, and owns a 4-entry return-address stack.

## Interface
- PROF_PILHA, 4, return-stack depth (entries of 8 bits); fixed at 4 for this revision
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- endereco_atual  in  8  current PC value (PC output endereco)
- mem_pronto  in  1  instruction memory ack; instruction valid this cycle
- tipo  in  3  decoder class: 000 seq, 001 jump, 010 branch, 011 call, 100 return, 101 halt, 110/111 treated as seq
- cond  in  1  branch condition from datapath flags
- alvo  in  8  jump/branch/call target
- exec_pronto  in  1  datapath finished executing the current instruction
- proximo  out  8  next PC value, to PC entrada
- sinalcontrole_pc  out  1  PC load control, 0 = PC loads/resets on this edge, 1 = hold
- reset_pc  out  1  synchronous clear request to PC (effective only with sinalcontrole_pc=0)
- mem_req  out  1  instruction fetch request
- carrega_ir  out  1  latch instruction register (one-cycle pulse)
- executa  out  1  start-execute pulse to datapath
- parado  out  1  processor halted
- erro_pilha  out  1  sticky stack overflow/underflow flag

## Operation
- All outputs are registered, decoded from the state and datapath registers.
- States:
  - INICIO: reset_pc=1, sinalcontrole_pc=0, proximo=0x00. Lasts 1 cycle after reset release, then BUSCA.
  - BUSCA: mem_req=1. Stays until mem_pronto=1. On that edge, carrega_ir pulses in the next cycle and the state goes to DECODE.
  - DECODE: 1 cycle. Samples tipo/cond/alvo and computes the next PC:
    - seq, or branch with cond=0: endereco_atual+1
    - jump, or branch with cond=1: alvo
    - call: push endereco_atual+1, next = alvo
    - return: pop, next = popped value
    - halt: go to PARADO, with no execute and no PC update
    - otherwise: go to EXECUTA
  - EXECUTA: executa=1 on the first cycle only. Waits for exec_pronto=1, then goes to ATUALIZA.
  - ATUALIZA: sinalcontrole_pc=0, reset_pc=0, proximo=computed value. The PC loads on this edge. Then BUSCA.
  - PARADO: parado=1, sinalcontrole_pc=1. Exit only via reset.
- Arithmetic: endereco_atual+1 is modulo 256 (0xFF → 0x00).
- Stack: 4 entries, pointer 0..4.
  - Call with pointer=4 (full): no push, erro_pilha=1, go to PARADO.
  - Return with pointer=0 (empty): erro_pilha=1, go to PARADO.
  - A stack error does not go through EXECUTA.
- mem_pronto outside BUSCA and exec_pronto outside EXECUTA are ignored.
- sinalcontrole_pc=1 in every state except INICIO and ATUALIZA.

## Timing
- Reset values (asserted asynchronously): state INICIO, proximo=0x00, sinalcontrole_pc=0, reset_pc=1, mem_req=0, carrega_ir=0, executa=0, parado=0, erro_pilha=0, stack pointer=0.
- Zero-wait instruction: 4 cycles (BUSCA, DECODE, EXECUTA, ATUALIZA). Each mem_pronto or exec_pronto wait cycle adds 1.
- First fetch: mem_req rises 1 cycle after reset deasserts, with the PC already cleared to 0x00.
- Reset mid-instruction (any state): immediate return to reset values. Stack contents are discarded and no partial PC load occurs.
- mem_pronto and exec_pronto must be held high for at least 1 cycle while in the respective state. Level is sampled on the rising edge.

## Test plan
- Reset release, mem_pronto and exec_pronto tied 1, tipo=000: PC sequence 0x00, 0x01, 0x02, with sinalcontrole_pc=0 exactly once per 4 cycles.
- endereco_atual=0xFF, tipo=000: proximo=0x00 in ATUALIZA (wrap).
- Branch with alvo=0x40: cond=1 gives PC=0x40; cond=0 at endereco_atual=0x10 gives PC=0x11. Jump with alvo=0x80 gives PC=0x80.
- Call at 0x05 to 0x30, then return: PC goes 0x30, then 0x06. Five nested calls: erro_pilha=1 and parado=1 on the 5th, PC unchanged.
- Return with an empty stack: erro_pilha=1, parado=1. halt (tipo=101): parado=1, executa never pulses, PC holds.
- mem_pronto delayed 3 cycles and exec_pronto delayed 2 cycles: instruction takes 9 cycles. Reset asserted during EXECUTA: outputs return to reset values in the same cycle, and the next fetch is from 0x00.

Source files
------------

// File: rtl/sequenciador_pc.sv
// Fetch/decode/execute sequencer that produces the next program counter value.
// It also owns the return-address stack used by call and return.
module sequenciador_pc #(
  parameter int PROF_PILHA = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] endereco_atual,
  input  logic       mem_pronto,
  input  logic [2:0] tipo,
  input  logic       cond,
  input  logic [7:0] alvo,
  input  logic       exec_pronto,
  output logic [7:0] proximo,
  output logic       sinalcontrole_pc,
  output logic       reset_pc,
  output logic       mem_req,
  output logic       carrega_ir,
  output logic       executa,
  output logic       parado,
  output logic       erro_pilha
);

  localparam int PW = $clog2(PROF_PILHA + 1);
  localparam int IW = $clog2(PROF_PILHA);
  localparam logic [PW-1:0] SP_CHEIO = PW'(PROF_PILHA);

  localparam logic [2:0] T_JUMP   = 3'b001;
  localparam logic [2:0] T_BRANCH = 3'b010;
  localparam logic [2:0] T_CALL   = 3'b011;
  localparam logic [2:0] T_RET    = 3'b100;
  localparam logic [2:0] T_HALT   = 3'b101;

  typedef enum logic [2:0] {
    INICIO,
    BUSCA,
    DECODE,
    EXECUTA,
    ATUALIZA,
    PARADO
  } estado_t;

  estado_t       estado_q;
  logic [PW-1:0] sp_q;
  logic [7:0]    pilha_q [PROF_PILHA];
  logic [7:0]    next_pc_q;
  logic [7:0]    next_pc_d;
  logic [7:0]    seq_pc;
  logic [IW-1:0] topo;
  logic          pilha_cheia;
  logic          pilha_vazia;
  logic          push_en;

  always_comb begin
    seq_pc      = endereco_atual + 8'd1;
    pilha_cheia = (sp_q == SP_CHEIO);
    pilha_vazia = (sp_q == '0);
    topo        = IW'(sp_q - 1'b1);
    push_en     = (estado_q == DECODE) && (tipo == T_CALL) && !pilha_cheia;
    next_pc_d   = seq_pc;
    case (tipo)
      T_JUMP:   next_pc_d = alvo;
      T_BRANCH: next_pc_d = cond ? alvo : seq_pc;
      T_CALL:   next_pc_d = alvo;
      T_RET:    next_pc_d = pilha_q[topo];
      default:  next_pc_d = seq_pc;
    endcase
  end

  // Stack storage needs no reset: the pointer alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push_en) begin
      pilha_q[sp_q[IW-1:0]] <= seq_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q         <= INICIO;
      sp_q             <= '0;
      next_pc_q        <= 8'h00;
      proximo          <= 8'h00;
      sinalcontrole_pc <= 1'b0;
      reset_pc         <= 1'b1;
      mem_req          <= 1'b0;
      carrega_ir       <= 1'b0;
      executa          <= 1'b0;
      parado           <= 1'b0;
      erro_pilha       <= 1'b0;
    end else begin
      carrega_ir <= 1'b0;
      executa    <= 1'b0;
      case (estado_q)
        INICIO: begin
          estado_q         <= BUSCA;
          reset_pc         <= 1'b0;
          sinalcontrole_pc <= 1'b1;
          mem_req          <= 1'b1;
        end
        BUSCA: begin
          if (mem_pronto) begin
            estado_q   <= DECODE;
            mem_req    <= 1'b0;
            carrega_ir <= 1'b1;
          end
        end
        DECODE: begin
          next_pc_q <= next_pc_d;
          if (tipo == T_HALT) begin
            estado_q <= PARADO;
            parado   <= 1'b1;
          end else if ((tipo == T_CALL && pilha_cheia) || (tipo == T_RET && pilha_vazia)) begin
            estado_q   <= PARADO;
            parado     <= 1'b1;
            erro_pilha <= 1'b1;
          end else begin
            estado_q <= EXECUTA;
            executa  <= 1'b1;
            if (tipo == T_CALL) begin
              sp_q <= sp_q + 1'b1;
            end else if (tipo == T_RET) begin
              sp_q <= sp_q - 1'b1;
            end
          end
        end
        EXECUTA: begin
          if (exec_pronto) begin
            estado_q         <= ATUALIZA;
            sinalcontrole_pc <= 1'b0;
            proximo          <= next_pc_q;
          end
        end
        ATUALIZA: begin
          estado_q         <= BUSCA;
          sinalcontrole_pc <= 1'b1;
          mem_req          <= 1'b1;
        end
        PARADO: begin
        end
        default: begin
          estado_q <= INICIO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_pc.sv
// Bench for sequenciador_pc: models the PC register externally and checks each
// instruction against an instruction-level reference with a queue-based stack.
module tb_sequenciador_pc;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_pronto = 1'b0;
  logic       exec_pronto = 1'b0;
  logic       cond = 1'b0;
  logic [2:0] tipo = 3'd0;
  logic [7:0] alvo = 8'h00;
  logic [7:0] pc;
  wire  [7:0] endereco_atual;
  logic [7:0] proximo;
  logic       sinalcontrole_pc, reset_pc, mem_req, carrega_ir, executa, parado, erro_pilha;

  int total = 0;
  int bad = 0;
  logic [7:0] ref_stack[$];
  bit err_model = 0;
  bit stp;

  sequenciador_pc dut (
    .clock(clock), .reset(reset), .endereco_atual(endereco_atual),
    .mem_pronto(mem_pronto), .tipo(tipo), .cond(cond), .alvo(alvo),
    .exec_pronto(exec_pronto), .proximo(proximo), .sinalcontrole_pc(sinalcontrole_pc),
    .reset_pc(reset_pc), .mem_req(mem_req), .carrega_ir(carrega_ir),
    .executa(executa), .parado(parado), .erro_pilha(erro_pilha)
  );

  always #5 clock = ~clock;

  assign endereco_atual = pc;

  // External PC register: loads (or clears) whenever the load control is low.
  always @(posedge clock) begin
    if (sinalcontrole_pc === 1'b0) pc <= (reset_pc === 1'b1) ? 8'h00 : proximo;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_proximo"}, proximo, 8'h00);
    chk({tag, "_sinalcontrole"}, sinalcontrole_pc, 1'b0);
    chk({tag, "_reset_pc"}, reset_pc, 1'b1);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_carrega_ir"}, carrega_ir, 1'b0);
    chk({tag, "_executa"}, executa, 1'b0);
    chk({tag, "_parado"}, parado, 1'b0);
    chk({tag, "_erro_pilha"}, erro_pilha, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst");
    ref_stack.delete();
    err_model = 0;
    @(negedge clock);
    reset = 1'b0;
    mem_pronto = 1'b0;
    exec_pronto = 1'b0;
    @(negedge clock);
    chk("post_rst_mem_req", mem_req, 1'b1);
    chk("post_rst_pc", pc, 8'h00);
    chk("post_rst_sinalcontrole", sinalcontrole_pc, 1'b1);
    $display("reset released: pc=%02h mem_req=%0b", pc, mem_req);
  endtask

  // Runs one instruction starting at a negedge inside the first BUSCA cycle.
  task automatic run_instr(input logic [2:0] t, input logic c, input logic [7:0] a,
                           input int mw, input int ew, output bit stopped);
    logic [7:0] pc0, exp_pc;
    bit stop_exp, done;
    int cyc, es, n_exec, n_load, n_ir, exp_cyc;
    pc0 = pc; exp_pc = pc; stop_exp = 0; done = 0;
    cyc = 0; es = -1; n_exec = 0; n_load = 0; n_ir = 0;
    case (t)
      3'd1: exp_pc = a;
      3'd2: exp_pc = c ? a : 8'(pc0 + 8'd1);
      3'd3: if (ref_stack.size() >= 4) begin stop_exp = 1; err_model = 1; end
            else begin ref_stack.push_back(8'(pc0 + 8'd1)); exp_pc = a; end
      3'd4: if (ref_stack.size() == 0) begin stop_exp = 1; err_model = 1; end
            else exp_pc = ref_stack.pop_back();
      3'd5: stop_exp = 1;
      default: exp_pc = 8'(pc0 + 8'd1);
    endcase
    exp_cyc = stop_exp ? 2 + mw : 4 + mw + ew;
    tipo = t; cond = c; alvo = a;
    while (!done && cyc < 40) begin
      if (executa === 1'b1) begin n_exec++; es = cyc; end
      if (carrega_ir === 1'b1) n_ir++;
      if (sinalcontrole_pc === 1'b0) begin
        n_load++;
        chk("proximo", proximo, exp_pc);
        chk("reset_pc_update", reset_pc, 1'b0);
      end
      if (stop_exp ? (parado === 1'b1) : (n_load > 0 && mem_req === 1'b1)) begin
        done = 1;
      end else begin
        mem_pronto = (cyc >= mw);
        exec_pronto = (es >= 0 && cyc - es >= ew);
        @(negedge clock);
        cyc++;
      end
    end
    mem_pronto = 1'b0;
    exec_pronto = 1'b0;
    chk("done", done, 1'b1);
    chk("cycles", cyc, exp_cyc);
    chk("carrega_ir_pulses", n_ir, 1);
    chk("executa_pulses", n_exec, stop_exp ? 0 : 1);
    chk("pc_loads", n_load, stop_exp ? 0 : 1);
    chk("pc", pc, exp_pc);
    chk("parado", parado, stop_exp);
    chk("erro_pilha", erro_pilha, err_model);
    $display("instr tipo=%0d cond=%0b alvo=%02h waits=%0d/%0d pc %02h->%02h cycles=%0d stop=%0b",
             t, c, a, mw, ew, pc0, pc, cyc, stop_exp);
    stopped = stop_exp;
  endtask

  initial begin
    do_reset();
    // sequential run with handshakes answered immediately
    for (int i = 0; i < 3; i++) run_instr(3'd0, 1'b0, 8'h00, 0, 0, stp);
    chk("seq_pc3", pc, 8'h03);
    // wrap from 0xFF
    run_instr(3'd1, 1'b0, 8'hFF, 0, 0, stp);
    run_instr(3'd0, 1'b0, 8'h00, 0, 0, stp);
    // branches and jump
    run_instr(3'd2, 1'b1, 8'h40, 0, 0, stp);
    run_instr(3'd1, 1'b0, 8'h10, 0, 0, stp);
    run_instr(3'd2, 1'b0, 8'h40, 0, 0, stp);
    run_instr(3'd1, 1'b0, 8'h80, 0, 0, stp);
    // call/return pair
    run_instr(3'd1, 1'b0, 8'h05, 0, 0, stp);
    run_instr(3'd3, 1'b0, 8'h30, 0, 0, stp);
    run_instr(3'd4, 1'b0, 8'h00, 0, 0, stp);
    chk("ret_pc", pc, 8'h06);
    // tipo 110/111 behave as sequential; slow handshakes give 9 cycles
    run_instr(3'd6, 1'b1, 8'h99, 1, 1, stp);
    run_instr(3'd7, 1'b0, 8'h99, 0, 0, stp);
    run_instr(3'd0, 1'b0, 8'h00, 3, 2, stp);
    // five nested calls overflow the stack on the fifth
    for (int i = 0; i < 5; i++) run_instr(3'd3, 1'b0, 8'(8'h20 + i), 0, 1, stp);
    do_reset();
    run_instr(3'd4, 1'b0, 8'h00, 0, 0, stp);
    do_reset();
    run_instr(3'd0, 1'b0, 8'h00, 0, 0, stp);
    run_instr(3'd5, 1'b0, 8'h00, 1, 0, stp);
    repeat (4) @(negedge clock);
    chk("halt_hold_pc", pc, 8'h01);
    chk("halt_no_executa", executa, 1'b0);
    do_reset();
    // randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [2:0] t;
      r = $urandom_range(0, 19);
      t = (r < 5) ? 3'd0 : (r < 8) ? 3'd1 : (r < 11) ? 3'd2 : (r < 14) ? 3'd3 :
          (r < 17) ? 3'd4 : (r < 18) ? 3'd5 : 3'(r - 12);
      run_instr(t, 1'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), stp);
      if (stp) do_reset();
    end
    // reset asserted during EXECUTA
    run_instr(3'd1, 1'b0, 8'h20, 0, 0, stp);
    tipo = 3'd1; alvo = 8'h77; mem_pronto = 1'b1; exec_pronto = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_executa", executa, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clock);
    chk("mid_rst_pc", pc, 8'h00);
    reset = 1'b0; mem_pronto = 1'b0;
    ref_stack.delete(); err_model = 0;
    @(negedge clock);
    chk("mid_rst_mem_req", mem_req, 1'b1);
    $display("reset during execute: pc=%02h", pc);
    run_instr(3'd0, 1'b0, 8'h00, 0, 0, stp);
    chk("mid_rst_next", pc, 8'h01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
